bof_range_table: RTL and testbench

- Storage and lookup side of the heap-overflow tracker.
- The tracker pushes completed contiguous-store ranges {first, last, big} into this table.
- Load-side checks query it every cycle with an effective address.
- Overlapping or adjacent ranges merge into one entry. When the table is full, the oldest non-big entry is evicted.

---
 rtl/bof_range_table.sv | 193 +++++++++++++++++++
 tb/tb_bof_range_table.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bof_range_table.sv
// Range table for the heap-overflow tracker: stores contiguous store ranges, merges
// overlapping/adjacent writes, evicts the oldest non-big entry when full.
module bof_range_table #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [ADDR_W-1:0]              wr_first_i,
  input  logic [ADDR_W-1:0]              wr_last_i,
  input  logic                           wr_big_i,
  input  logic [ADDR_W-1:0]              find_addr_i,
  output logic                           addr_in_range_o,
  output logic                           addr_is_first_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] hit_idx_o,
  output logic [ADDR_W-1:0]              read_o,
  output logic [ADDR_W-1:0]              read2_o,
  output logic [$clog2(NUM_ENTRIES):0]   occupancy_o,
  output logic                           merge_o,
  output logic                           evict_o
);

  localparam int unsigned       IdxW    = $clog2(NUM_ENTRIES);
  localparam logic [IdxW-1:0]   IdxOne  = 1;
  localparam logic [IdxW:0]     OccOne  = 1;
  localparam logic [ADDR_W:0]   WideOne = 1;

  typedef enum logic [1:0] {StIdle, StCmp, StCommit} state_e;

  state_e                  state_q;
  logic [NUM_ENTRIES-1:0]  valid_q;
  logic [NUM_ENTRIES-1:0]  big_q;
  logic [ADDR_W-1:0]       first_q [NUM_ENTRIES];
  logic [ADDR_W-1:0]       last_q  [NUM_ENTRIES];
  logic [ADDR_W-1:0]       req_first_q;
  logic [ADDR_W-1:0]       req_last_q;
  logic                    req_big_q;
  logic                    match_q;
  logic [IdxW-1:0]         match_idx_q;
  logic [IdxW-1:0]         rr_ptr_q;

  logic                    cmp_match;
  logic [IdxW-1:0]         cmp_idx;
  logic                    full;
  logic [IdxW-1:0]         free_idx;
  logic                    victim_found;
  logic [IdxW-1:0]         victim_idx;
  logic [IdxW-1:0]         scan_idx;
  logic [IdxW-1:0]         tgt_idx;
  logic [ADDR_W-1:0]       new_first;
  logic [ADDR_W-1:0]       new_last;
  logic                    new_big;

  assign wr_ready_o = (state_q == StIdle);

  // Descending scan so the lowest index is the final winner.
  always_comb begin
    addr_in_range_o = 1'b0;
    addr_is_first_o = 1'b0;
    hit_idx_o       = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && find_addr_i >= first_q[i] && find_addr_i <= last_q[i]) begin
        addr_in_range_o = 1'b1;
        addr_is_first_o = (find_addr_i == first_q[i]);
        hit_idx_o       = IdxW'(i);
      end
    end
  end

  // Overlap-or-adjacent test, widened by one bit so last+1 cannot wrap.
  always_comb begin
    cmp_match = 1'b0;
    cmp_idx   = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          ({1'b0, req_first_q} <= {1'b0, last_q[i]} + WideOne) &&
          ({1'b0, req_last_q} + WideOne >= {1'b0, first_q[i]})) begin
        cmp_match = 1'b1;
        cmp_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    full     = &valid_q;
    free_idx = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IdxW'(i);
    end
    victim_found = 1'b0;
    victim_idx   = rr_ptr_q;
    scan_idx     = rr_ptr_q;
    for (int k = 0; k < int'(NUM_ENTRIES); k++) begin
      scan_idx = rr_ptr_q + IdxW'(k);
      if (!victim_found && !big_q[scan_idx]) begin
        victim_found = 1'b1;
        victim_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    if (match_q) begin
      tgt_idx   = match_idx_q;
      new_first = (req_first_q < first_q[match_idx_q]) ? req_first_q : first_q[match_idx_q];
      new_last  = (req_last_q > last_q[match_idx_q]) ? req_last_q : last_q[match_idx_q];
      new_big   = big_q[match_idx_q] | req_big_q;
    end else begin
      tgt_idx   = full ? victim_idx : free_idx;
      new_first = req_first_q;
      new_last  = req_last_q;
      new_big   = req_big_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      big_q       <= '0;
      rr_ptr_q    <= '0;
      occupancy_o <= '0;
      merge_o     <= 1'b0;
      evict_o     <= 1'b0;
      read_o      <= '0;
      read2_o     <= '0;
      req_first_q <= '0;
      req_last_q  <= '0;
      req_big_q   <= 1'b0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
    end else if (flush_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      big_q       <= '0;
      rr_ptr_q    <= '0;
      occupancy_o <= '0;
      merge_o     <= 1'b0;
      evict_o     <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      merge_o <= 1'b0;
      evict_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (wr_valid_i) begin
            req_first_q <= wr_first_i;
            req_last_q  <= wr_last_i;
            req_big_q   <= wr_big_i;
            state_q     <= StCmp;
          end
        end
        StCmp: begin
          if (req_first_q > req_last_q) begin
            state_q <= StIdle;
          end else begin
            match_q     <= cmp_match;
            match_idx_q <= cmp_idx;
            state_q     <= StCommit;
          end
        end
        StCommit: begin
          valid_q[tgt_idx] <= 1'b1;
          big_q[tgt_idx]   <= new_big;
          read_o           <= new_first;
          read2_o          <= new_last;
          if (match_q) begin
            merge_o <= 1'b1;
          end else if (full) begin
            evict_o  <= 1'b1;
            rr_ptr_q <= victim_idx + IdxOne;
          end else begin
            occupancy_o <= occupancy_o + OccOne;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Range bounds are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && state_q == StCommit) begin
      first_q[tgt_idx] <= new_first;
      last_q[tgt_idx]  <= new_last;
    end
  end

endmodule

// File: tb/tb_bof_range_table.sv
// Self-checking bench for bof_range_table: directed scenarios plus a randomized run
// compared against a table model kept in plain arrays.
module tb_bof_range_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_first = '0;
  logic [31:0] wr_last = '0;
  logic        wr_big = 1'b0;
  logic [31:0] find_addr = '0;
  logic        in_range;
  logic        is_first;
  logic [2:0]  hit_idx;
  logic [31:0] rd;
  logic [31:0] rd2;
  logic [3:0]  occ;
  logic        mg;
  logic        ev;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_valid [8];
  bit          m_big   [8];
  logic [31:0] m_first [8];
  logic [31:0] m_last  [8];
  int          m_rr;
  int          m_occ;
  logic [31:0] m_read;
  logic [31:0] m_read2;

  always #5 clk = ~clk;

  bof_range_table #(.NUM_ENTRIES(8), .ADDR_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .wr_first_i      (wr_first),
    .wr_last_i       (wr_last),
    .wr_big_i        (wr_big),
    .find_addr_i     (find_addr),
    .addr_in_range_o (in_range),
    .addr_is_first_o (is_first),
    .hit_idx_o       (hit_idx),
    .read_o          (rd),
    .read2_o         (rd2),
    .occupancy_o     (occ),
    .merge_o         (mg),
    .evict_o         (ev)
  );

  function automatic void model_clear(input bit keep_read);
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_big[i]   = 1'b0;
    end
    m_rr  = 0;
    m_occ = 0;
    if (!keep_read) begin
      m_read  = '0;
      m_read2 = '0;
    end
  endfunction

  function automatic void model_write(input logic [31:0] f, input logic [31:0] l, input bit b,
                                      output bit emg, output bit eev);
    longint lf = longint'(f);
    longint ll = longint'(l);
    int     hit = -1;
    int     slot = -1;
    emg = 1'b0;
    eev = 1'b0;
    if (f > l) return;
    for (int i = 0; i < 8; i++) begin
      if (hit < 0 && m_valid[i] && lf <= longint'(m_last[i]) + 1 &&
          ll + 1 >= longint'(m_first[i])) hit = i;
    end
    if (hit >= 0) begin
      if (f < m_first[hit]) m_first[hit] = f;
      if (l > m_last[hit]) m_last[hit] = l;
      m_big[hit] = m_big[hit] | b;
      emg = 1'b1;
      slot = hit;
    end else begin
      for (int i = 0; i < 8; i++) if (slot < 0 && !m_valid[i]) slot = i;
      if (slot >= 0) begin
        m_occ++;
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (slot < 0 && !m_big[(m_rr + k) % 8]) slot = (m_rr + k) % 8;
        end
        if (slot < 0) slot = m_rr;
        m_rr = (slot + 1) % 8;
        eev  = 1'b1;
      end
      m_valid[slot] = 1'b1;
      m_first[slot] = f;
      m_last[slot]  = l;
      m_big[slot]   = b;
    end
    m_read  = m_first[slot];
    m_read2 = m_last[slot];
  endfunction

  function automatic void model_find(input logic [31:0] a, output bit h, output bit f1,
                                     output logic [2:0] idx);
    h   = 1'b0;
    f1  = 1'b0;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!h && m_valid[i] && a >= m_first[i] && a <= m_last[i]) begin
        h   = 1'b1;
        f1  = (a == m_first[i]);
        idx = 3'(i);
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear(1'b0);
  endtask

  // Drives one request and records ready and pulse observations per cycle after accept.
  task automatic do_write(input logic [31:0] f, input logic [31:0] l, input bit b,
                          output bit r1, output bit r2, output bit r3,
                          output bit m, output bit e, output bit m2, output bit e2);
    @(negedge clk);
    for (int k = 0; k < 8 && !wr_ready; k++) @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_req: got %b expected 1", wr_ready);
    end
    wr_first = f;
    wr_last  = l;
    wr_big   = b;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    r1 = wr_ready;
    @(negedge clk);
    r2 = wr_ready;
    @(negedge clk);
    r3 = wr_ready;
    m  = mg;
    e  = ev;
    @(negedge clk);
    m2 = mg;
    e2 = ev;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear(1'b0);
    find_addr = 32'h1000;
    #1;
    n_cmp += 6;
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
    if (occ !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    if (rd !== 32'h0 || rd2 !== 32'h0) begin
      n_err++; $display("FAIL reset_read: got %h/%h expected 0/0", rd, rd2);
    end
    if (mg !== 1'b0 || ev !== 1'b0) begin
      n_err++; $display("FAIL reset_pulse: got %b%b expected 00", mg, ev);
    end
    if (in_range !== 1'b0) begin n_err++; $display("FAIL reset_lookup: got %b expected 0", in_range); end
    if (hit_idx !== 3'd0) begin n_err++; $display("FAIL reset_hit_idx: got %0d expected 0", hit_idx); end
  endtask

  task automatic test_basic();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    model_write(32'h1000, 32'h101F, 1'b0, emg, eev);
    do_write(32'h1000, 32'h101F, 1'b0, r1, r2, r3, m, e, m2, e2);
    find_addr = 32'h1010;
    #1;
    n_cmp += 8;
    if ({r1, r2, r3} !== 3'b001) begin
      n_err++; $display("FAIL basic_ready: got %b expected 001", {r1, r2, r3});
    end
    if (m !== emg || e !== eev) begin
      n_err++; $display("FAIL basic_pulse: got %b%b expected %b%b", m, e, emg, eev);
    end
    if (in_range !== 1'b1) begin n_err++; $display("FAIL basic_hit: got %b expected 1", in_range); end
    if (hit_idx !== 3'd0) begin n_err++; $display("FAIL basic_idx: got %0d expected 0", hit_idx); end
    if (is_first !== 1'b0) begin n_err++; $display("FAIL basic_notfirst: got %b expected 0", is_first); end
    if (occ !== 4'd1) begin n_err++; $display("FAIL basic_occ: got %0d expected 1", occ); end
    if (rd !== 32'h1000 || rd2 !== 32'h101F) begin
      n_err++; $display("FAIL basic_read: got %h/%h expected 00001000/0000101f", rd, rd2);
    end
    find_addr = 32'h1000;
    #1;
    if (is_first !== 1'b1) begin n_err++; $display("FAIL basic_first: got %b expected 1", is_first); end
  endtask

  task automatic test_merge();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    model_write(32'h1020, 32'h103F, 1'b0, emg, eev);
    do_write(32'h1020, 32'h103F, 1'b0, r1, r2, r3, m, e, m2, e2);
    n_cmp += 6;
    if (m !== 1'b1 || e !== 1'b0) begin
      n_err++; $display("FAIL merge_pulse: got %b%b expected 10", m, e);
    end
    if (m2 !== 1'b0 || e2 !== 1'b0) begin
      n_err++; $display("FAIL merge_one_cycle: got %b%b expected 00", m2, e2);
    end
    if (occ !== 4'd1) begin n_err++; $display("FAIL merge_occ: got %0d expected 1", occ); end
    if (rd !== 32'h1000 || rd2 !== 32'h103F) begin
      n_err++; $display("FAIL merge_read: got %h/%h expected 00001000/0000103f", rd, rd2);
    end
    find_addr = 32'h1030;
    #1;
    if (in_range !== 1'b1) begin n_err++; $display("FAIL merge_hit: got %b expected 1", in_range); end
    find_addr = 32'h1040;
    #1;
    if (in_range !== 1'b0) begin n_err++; $display("FAIL merge_miss: got %b expected 0", in_range); end
  endtask

  task automatic test_evict();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] f;
      f = 32'h0001_0000 * (i + 1);
      model_write(f, f + 32'hFF, i < 2, emg, eev);
      do_write(f, f + 32'hFF, i < 2, r1, r2, r3, m, e, m2, e2);
      n_cmp++;
      if (m !== emg || e !== eev) begin
        n_err++; $display("FAIL fill_pulse[%0d]: got %b%b expected %b%b", i, m, e, emg, eev);
      end
    end
    model_write(32'h00A0_0000, 32'h00A0_00FF, 1'b0, emg, eev);
    do_write(32'h00A0_0000, 32'h00A0_00FF, 1'b0, r1, r2, r3, m, e, m2, e2);
    n_cmp += 6;
    if (m !== 1'b0 || e !== 1'b1) begin
      n_err++; $display("FAIL evict_pulse: got %b%b expected 01", m, e);
    end
    if (e2 !== 1'b0) begin n_err++; $display("FAIL evict_one_cycle: got %b expected 0", e2); end
    if (occ !== 4'd8) begin n_err++; $display("FAIL evict_occ: got %0d expected 8", occ); end
    find_addr = 32'h0003_0010;
    #1;
    if (in_range !== 1'b0) begin n_err++; $display("FAIL evict_old_miss: got %b expected 0", in_range); end
    find_addr = 32'h00A0_0010;
    #1;
    if (in_range !== 1'b1 || hit_idx !== 3'd2) begin
      n_err++; $display("FAIL evict_new_hit: got %b/%0d expected 1/2", in_range, hit_idx);
    end
    model_write(32'h00B0_0000, 32'h00B0_00FF, 1'b0, emg, eev);
    do_write(32'h00B0_0000, 32'h00B0_00FF, 1'b0, r1, r2, r3, m, e, m2, e2);
    find_addr = 32'h00B0_0000;
    #1;
    if (hit_idx !== 3'd3 || is_first !== 1'b1) begin
      n_err++; $display("FAIL evict_rr_next: got %0d/%b expected 3/1", hit_idx, is_first);
    end
  endtask

  task automatic test_all_big();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      logic [31:0] f;
      f = 32'h0100_0000 + 32'h1000 * i;
      model_write(f, f + 32'h10, 1'b1, emg, eev);
      do_write(f, f + 32'h10, 1'b1, r1, r2, r3, m, e, m2, e2);
      if (i >= 8) begin
        find_addr = f;
        #1;
        n_cmp++;
        if (e !== 1'b1 || hit_idx !== 3'(i - 8)) begin
          n_err++; $display("FAIL bigfill_evict[%0d]: got %b/%0d expected 1/%0d", i, e, hit_idx, i - 8);
        end
      end
    end
    model_write(32'h0200_0000, 32'h0200_0040, 1'b0, emg, eev);
    do_write(32'h0200_0000, 32'h0200_0040, 1'b0, r1, r2, r3, m, e, m2, e2);
    find_addr = 32'h0200_0020;
    #1;
    n_cmp += 2;
    if (e !== 1'b1 || m !== 1'b0) begin
      n_err++; $display("FAIL allbig_pulse: got %b%b expected 01", m, e);
    end
    if (in_range !== 1'b1 || hit_idx !== 3'd5) begin
      n_err++; $display("FAIL allbig_victim: got %b/%0d expected 1/5", in_range, hit_idx);
    end
  endtask

  task automatic test_drop_wrap();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    do_reset();
    model_write(32'h500, 32'h5FF, 1'b0, emg, eev);
    do_write(32'h500, 32'h5FF, 1'b0, r1, r2, r3, m, e, m2, e2);
    model_write(32'h2000, 32'h1FFF, 1'b0, emg, eev);
    do_write(32'h2000, 32'h1FFF, 1'b0, r1, r2, r3, m, e, m2, e2);
    n_cmp += 4;
    if ({r1, r2} !== 2'b01) begin n_err++; $display("FAIL drop_ready: got %b expected 01", {r1, r2}); end
    if ({m, e, m2, e2} !== 4'b0000) begin
      n_err++; $display("FAIL drop_pulse: got %b expected 0000", {m, e, m2, e2});
    end
    if (occ !== 4'(m_occ)) begin n_err++; $display("FAIL drop_occ: got %0d expected %0d", occ, m_occ); end
    if (rd !== m_read) begin n_err++; $display("FAIL drop_read: got %h expected %h", rd, m_read); end
    model_write(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, emg, eev);
    do_write(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, r1, r2, r3, m, e, m2, e2);
    find_addr = 32'h0;
    #1;
    n_cmp += 3;
    if (in_range !== 1'b0) begin n_err++; $display("FAIL wrap_zero_miss: got %b expected 0", in_range); end
    if (occ !== 4'd2) begin n_err++; $display("FAIL wrap_occ: got %0d expected 2", occ); end
    find_addr = 32'hFFFF_FFFF;
    #1;
    if (in_range !== 1'b1 || hit_idx !== 3'd1) begin
      n_err++; $display("FAIL wrap_top_hit: got %b/%0d expected 1/1", in_range, hit_idx);
    end
  endtask

  task automatic test_flush();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    do_reset();
    model_write(32'h3000, 32'h30FF, 1'b1, emg, eev);
    do_write(32'h3000, 32'h30FF, 1'b1, r1, r2, r3, m, e, m2, e2);
    @(negedge clk);
    wr_first = 32'h3100;
    wr_last  = 32'h31FF;
    wr_big   = 1'b0;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear(1'b1);
    find_addr = 32'h3010;
    #1;
    n_cmp += 5;
    if (occ !== 4'd0) begin n_err++; $display("FAIL flush_occ: got %0d expected 0", occ); end
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b expected 1", wr_ready); end
    if (in_range !== 1'b0) begin n_err++; $display("FAIL flush_lookup: got %b expected 0", in_range); end
    if (rd !== m_read || rd2 !== m_read2) begin
      n_err++; $display("FAIL flush_read_kept: got %h/%h expected %h/%h", rd, rd2, m_read, m_read2);
    end
    if (mg !== 1'b0 || ev !== 1'b0) begin
      n_err++; $display("FAIL flush_pulse: got %b%b expected 00", mg, ev);
    end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (mg !== 1'b0 || ev !== 1'b0 || occ !== 4'd0) begin
        n_err++; $display("FAIL flush_after: got %b%b/%0d expected 00/0", mg, ev, occ);
      end
    end
  endtask

  task automatic test_rst_commit();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    model_write(32'h4000, 32'h40FF, 1'b0, emg, eev);
    do_write(32'h4000, 32'h40FF, 1'b0, r1, r2, r3, m, e, m2, e2);
    @(negedge clk);
    wr_first = 32'h5000;
    wr_last  = 32'h50FF;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear(1'b0);
    n_cmp += 3;
    if (rd !== 32'h0 || rd2 !== 32'h0) begin
      n_err++; $display("FAIL rst_commit_read: got %h/%h expected 0/0", rd, rd2);
    end
    if (occ !== 4'd0 || mg !== 1'b0 || ev !== 1'b0) begin
      n_err++; $display("FAIL rst_commit_state: got %0d/%b%b expected 0/00", occ, mg, ev);
    end
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_commit_ready: got %b expected 1", wr_ready); end
  endtask

  task automatic test_random();
    bit r1, r2, r3, m, e, m2, e2, emg, eev;
    logic [31:0] f, l, a, tmp;
    bit b, drop, h, f1;
    logic [2:0] idx;
    do_reset();
    for (int it = 0; it < 250; it++) begin
      f = $urandom_range(0, 4095);
      l = f + $urandom_range(0, 48);
      if ($urandom_range(0, 9) == 0) begin tmp = f; f = l; l = tmp; end
      b = ($urandom_range(0, 4) == 0);
      drop = (f > l);
      model_write(f, l, b, emg, eev);
      do_write(f, l, b, r1, r2, r3, m, e, m2, e2);
      n_cmp += 4;
      if (r1 !== 1'b0 || r2 !== drop || r3 !== 1'b1) begin
        n_err++; $display("FAIL rnd_ready[%0d]: got %b%b%b expected 0%b1", it, r1, r2, r3, drop);
      end
      if (m !== emg || e !== eev || m2 !== 1'b0 || e2 !== 1'b0) begin
        n_err++; $display("FAIL rnd_pulse[%0d]: got %b%b%b%b expected %b%b00", it, m, e, m2, e2, emg, eev);
      end
      if (occ !== 4'(m_occ)) begin
        n_err++; $display("FAIL rnd_occ[%0d]: got %0d expected %0d", it, occ, m_occ);
      end
      if (rd !== m_read || rd2 !== m_read2) begin
        n_err++; $display("FAIL rnd_read[%0d]: got %h/%h expected %h/%h", it, rd, rd2, m_read, m_read2);
      end
      for (int j = 0; j < 4; j++) begin
        int en;
        en = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1 && m_valid[en])
          a = m_first[en] - 2 + $urandom_range(0, 4) + $urandom_range(0, m_last[en] - m_first[en]);
        else
          a = $urandom_range(0, 4200);
        model_find(a, h, f1, idx);
        find_addr = a;
        #1;
        n_cmp++;
        if (in_range !== h || hit_idx !== idx || is_first !== f1) begin
          n_err++;
          $display("FAIL rnd_lookup[%0d] addr %h: got %b/%0d/%b expected %b/%0d/%b",
                   it, a, in_range, hit_idx, is_first, h, idx, f1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_merge();
    test_evict();
    test_all_big();
    test_drop_wrap();
    test_flush();
    test_rst_commit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
